friscv_mc_ctrl: RTL
===================

# friscv_mc_ctrl

Multi-cycle control unit for the FRiscV RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, and drives the shared ALU (4-bit ALU op encoding from `friscv_pkg`), PC, instruction register, register file and memory request strobes. It sits between the datapath (PC/IR/regfile/ALU/result registers) and the instruction/data memories, and handshakes with both memories.

## Interface
- `ARCH`, 32: instruction/datapath width; the block supports only 32.
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `instr_i` in 32: IR contents; stable from DECODE until return to FETCH.
- `mem_ready_i` in 1: memory completion; sampled only in FETCH and MEM.
- `alu_zero_i` in 1: ALU result == 0, from the current-cycle result.
- `alu_lsb_i` in 1: ALU result bit 0, from the current-cycle result.
- `imem_req_o` out 1: instruction fetch request.
- `ir_we_o` out 1: load IR from imem read data.
- `dmem_req_o` out 1: data memory request.
- `dmem_we_o` out 1: data memory write (store).
- `dmem_funct_o` out 3: funct3 of the load/store, giving size and sign.
- `alu_op_o` out 4: ALU op (AND 0, OR 1, XOR 2, ADD 3, SUB 4, SLT 5, SLL 6, SAR 7, SLR 8).
- `alu_src_a_o` out 2: operand A: 0 rs1, 1 PC, 2 zero.
- `alu_src_b_o` out 2: operand B: 0 rs2, 1 immediate, 2 constant 4.
- `pc_we_o` out 1: PC write enable.
- `pc_src_o` out 2: next PC: 0 PC+4, 1 ALU result with bit 0 cleared (JALR), 2 PC+imm (branch/JAL).
- `rf_we_o` out 1: register file write enable.
- `wb_sel_o` out 2: writeback source: 0 registered ALU result, 1 load data, 2 PC+4.
- `retire_o` out 1: one-cycle pulse when an instruction completes.
- `halt_o` out 1: trap state indicator (macro-dependent).

## Operation
- The FSM has the states FETCH, DECODE, EXEC, MEM, WB and TRAP. Reset state is FETCH.
- All outputs are 0 while `rst_n` is low. Outputs are combinational from the state and `instr_i`.
- FETCH: `imem_req_o`=1. The block stays in FETCH until `mem_ready_i`=1. In that cycle `ir_we_o`=1 and the FSM moves to DECODE.
- DECODE: one cycle for the regfile read. The FSM moves to EXEC, or to TRAP on an illegal instruction.
- EXEC by class:
  - OP/OP-IMM: ALU op from funct3/funct7. SUB when funct7[5]=1 (R-type only). SAR/SLR are selected by funct7[5]. Then WB.
  - LUI: ADD, A=zero, B=imm, then WB.
  - AUIPC: ADD, A=PC, B=imm, then WB.
  - LOAD/STORE: ADD, A=rs1, B=imm (address), then MEM.
  - BRANCH: BEQ/BNE use SUB and test `alu_zero_i`. BLT/BGE use SLT and test `alu_lsb_i`. In the same cycle `pc_we_o`=1, `pc_src_o` = 2 if taken else 0, and `retire_o`=1. Then FETCH.
  - JAL: `pc_src_o`=2. JALR: ADD rs1+imm, `pc_src_o`=1. Both assert `pc_we_o` in EXEC and then go to WB with `wb_sel_o`=2. The datapath latches the old PC+4.
- MEM: `dmem_req_o`=1, `dmem_we_o` = store, `dmem_funct_o` = funct3. These are held until `mem_ready_i`=1.
  - Store completion: `pc_we_o`=1, `pc_src_o`=0, `retire_o`=1, then FETCH.
  - Load completion: go to WB with `wb_sel_o`=1.
- WB: `rf_we_o`=1 and `retire_o`=1, then FETCH. `pc_we_o`=1 with `pc_src_o`=0, except for JAL/JALR, whose PC was already written.
- `rf_we_o` is suppressed when rd=x0.
- Illegal instructions in this revision: unknown opcode, SLT(I)U, BLTU/BGEU, FENCE/SYSTEM, and invalid funct7 on OP.

## Timing
- Cycle counts with zero memory wait:
  - ALU/LUI/AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL/JALR: 4 cycles.
- Each memory wait cycle adds exactly 1 cycle.
- Requests are level signals and stay stable until the completing cycle. They drop in the cycle after `mem_ready_i` is sampled high.
- `mem_ready_i` is ignored in DECODE, EXEC, WB and TRAP, including when it arrives early or is stuck high.
- Reset asserted mid-FETCH or mid-MEM: the request drops immediately (asynchronously). After reset release the FSM restarts in FETCH. Memory must discard the abandoned access.
- `retire_o` is never high for two consecutive cycles.

## Configuration
- `FRISCV_ILLEGAL_TRAP_EN` defined: an illegal instruction in DECODE goes to TRAP. In TRAP `halt_o`=1, all other outputs are 0, and the FSM stays there until reset.
- Not defined: an illegal instruction is a NOP. DECODE asserts `pc_we_o`=1, `pc_src_o`=0, `retire_o`=1 and returns to FETCH. The `halt_o` output exists but is tied to 0.

## Test plan
- ADD x3,x1,x2 (0x002081B3) with immediate `mem_ready_i`: check the FETCH→DECODE→EXEC→WB sequence; `alu_op_o`=3 in EXEC; `rf_we_o` and `retire_o` high in cycle 4.
- LW x5,8(x1) with 3 FETCH wait cycles and 2 MEM wait cycles: check `imem_req_o` held 4 cycles, `dmem_req_o` held 3 cycles with `dmem_we_o`=0 and `dmem_funct_o`=2, and retire at cycle 10.
- BEQ with `alu_zero_i`=1, then with `alu_zero_i`=0: check `alu_op_o`=4, `pc_src_o`=2 then 0, and retire in cycle 3 with no `rf_we_o`.
- SRA x4,x4,x1 (funct7=0x20): check `alu_op_o`=7. SRL: check `alu_op_o`=8. SUB with rd=x0: check `rf_we_o`=0 while `retire_o`=1.
- Opcode 0x73 (ECALL): with the macro, check `halt_o`=1 permanently and `mem_ready_i` pulses ignored. Without the macro, check retire in DECODE with PC+4 and the next fetch proceeding.
- Assert `rst_n` low during MEM with `dmem_req_o`=1: check all outputs are 0 in the same cycle, and `imem_req_o`=1 in the first cycle after release.

Source files
------------

// File: rtl/friscv_mc_ctrl.sv
// Multi-cycle FRiscV RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshakes.
// Define FRISCV_ILLEGAL_TRAP_EN to halt in TRAP on an illegal instruction; otherwise illegal ops retire as NOPs.
module friscv_mc_ctrl #(
  parameter int ARCH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ARCH-1:0] instr_i,
  input  logic            mem_ready_i,
  input  logic            alu_zero_i,
  input  logic            alu_lsb_i,
  output logic            imem_req_o,
  output logic            ir_we_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [2:0]      dmem_funct_o,
  output logic [3:0]      alu_op_o,
  output logic [1:0]      alu_src_a_o,
  output logic [1:0]      alu_src_b_o,
  output logic            pc_we_o,
  output logic [1:0]      pc_src_o,
  output logic            rf_we_o,
  output logic [1:0]      wb_sel_o,
  output logic            retire_o,
  output logic            halt_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_XOR = 4'd2, ALU_ADD = 4'd3, ALU_SUB = 4'd4,
    ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SAR = 4'd7, ALU_SLR = 4'd8
  } alu_op_e;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LUI, C_AUIPC, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_NONE
  } class_e;

  state_e  state_q, state_d;
  class_e  cls;
  alu_op_e arith_op;
  logic    illegal;
  logic    br_taken;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       unused_bits;

  assign opcode      = instr_i[6:0];
  assign rd          = instr_i[11:7];
  assign f3          = instr_i[14:12];
  assign f7          = instr_i[31:25];
  assign unused_bits = ^instr_i[24:15];

  // funct7[5] only means SUB for R-type; for OP-IMM it is immediate data
  always_comb begin
    arith_op = ALU_ADD;
    case (f3)
      3'b000:  arith_op = (f7[5] && opcode[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLT;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = f7[5] ? ALU_SAR : ALU_SLR;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    cls     = C_NONE;
    illegal = 1'b1;
    case (opcode)
      7'h33: begin
        cls     = C_OP;
        illegal = (f3 == 3'b011) ||
                  !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      7'h13: begin
        cls     = C_OPIMM;
        illegal = (f3 == 3'b011) ||
                  ((f3 == 3'b001) && (f7 != 7'h00)) ||
                  ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      7'h37: begin cls = C_LUI;   illegal = 1'b0; end
      7'h17: begin cls = C_AUIPC; illegal = 1'b0; end
      7'h6f: begin cls = C_JAL;   illegal = 1'b0; end
      7'h67: begin cls = C_JALR;  illegal = 1'b0; end
      7'h03: begin
        cls     = C_LOAD;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'h23: begin
        cls     = C_STORE;
        illegal = f3[2] || (f3[1:0] == 2'b11);
      end
      7'h63: begin
        cls     = C_BRANCH;
        illegal = (f3[2:1] == 2'b01) || (f3[2:1] == 2'b11);
      end
      default: begin
        cls     = C_NONE;
        illegal = 1'b1;
      end
    endcase
  end

  // BEQ/BNE test zero of SUB, BLT/BGE test bit 0 of SLT; funct3[0] inverts the sense
  assign br_taken = f3[2] ? (alu_lsb_i ^ f3[0]) : (alu_zero_i ^ f3[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Every output is gated by rst_n so requests drop the moment reset asserts
  always_comb begin
    state_d      = state_q;
    imem_req_o   = 1'b0;
    ir_we_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_funct_o = '0;
    alu_op_o     = '0;
    alu_src_a_o  = '0;
    alu_src_b_o  = '0;
    pc_we_o      = 1'b0;
    pc_src_o     = '0;
    rf_we_o      = 1'b0;
    wb_sel_o     = '0;
    retire_o     = 1'b0;
    halt_o       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_we_o = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: begin
          if (illegal) begin
`ifdef FRISCV_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = S_FETCH;
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          state_d = S_WB;
          case (cls)
            C_OP: alu_op_o = arith_op;
            C_OPIMM: begin
              alu_op_o    = arith_op;
              alu_src_b_o = 2'd1;
            end
            C_LUI: begin
              alu_op_o    = ALU_ADD;
              alu_src_a_o = 2'd2;
              alu_src_b_o = 2'd1;
            end
            C_AUIPC: begin
              alu_op_o    = ALU_ADD;
              alu_src_a_o = 2'd1;
              alu_src_b_o = 2'd1;
            end
            C_LOAD, C_STORE: begin
              alu_op_o    = ALU_ADD;
              alu_src_b_o = 2'd1;
              state_d     = S_MEM;
            end
            C_BRANCH: begin
              alu_op_o = f3[2] ? ALU_SLT : ALU_SUB;
              pc_we_o  = 1'b1;
              pc_src_o = br_taken ? 2'd2 : 2'd0;
              retire_o = 1'b1;
              state_d  = S_FETCH;
            end
            C_JAL: begin
              pc_we_o  = 1'b1;
              pc_src_o = 2'd2;
            end
            C_JALR: begin
              alu_op_o    = ALU_ADD;
              alu_src_b_o = 2'd1;
              pc_we_o     = 1'b1;
              pc_src_o    = 2'd1;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = (cls == C_STORE);
          dmem_funct_o = f3;
          if (mem_ready_i) begin
            if (cls == C_STORE) begin
              pc_we_o  = 1'b1;
              retire_o = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          rf_we_o  = (rd != 5'd0);
          retire_o = 1'b1;
          state_d  = S_FETCH;
          case (cls)
            C_LOAD: begin
              wb_sel_o = 2'd1;
              pc_we_o  = 1'b1;
            end
            C_JAL, C_JALR: wb_sel_o = 2'd2;
            default: pc_we_o = 1'b1;
          endcase
        end
        S_TRAP: begin
`ifdef FRISCV_ILLEGAL_TRAP_EN
          halt_o = 1'b1;
`endif
          state_d = S_TRAP;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule
